// File: rtl/upg_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : upg_session_ctrl
// Purpose  : Sequences one UART program-download session and gates the CPU
//            reset. Optional feature macro: UPG_CHECKSUM_EN (data checksum).
// Revision : 1.0
// ============================================================================
module upg_session_ctrl #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int DRAIN_CYC   = 16,
    parameter int CNT_W       = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_pg,
    input  logic             abort,
    input  logic             upg_wen_i,
    input  logic [14:0]      upg_adr_i,
    input  logic [31:0]      upg_dat_i,
    input  logic             upg_done_i,
    output logic             upg_rst_o,
    output logic             cpu_rst_o,
    output logic             imem_wen_o,
    output logic             dmem_wen_o,
    output logic [CNT_W-1:0] imem_cnt_o,
    output logic [CNT_W-1:0] dmem_cnt_o,
    output logic [2:0]       state_o,
    output logic             err_o,
    output logic [31:0]      chk_o
);

    localparam int               C_TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int               C_DRN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [C_DRN_W-1:0] C_DRN_LAST = C_DRN_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0]   C_CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_arm_entry;
    logic               w_accept;
    logic [C_TMO_W-1:0] r_tmo;
    logic [C_DRN_W-1:0] r_drain;
    logic [CNT_W-1:0]   r_imem_cnt;
    logic [CNT_W-1:0]   r_dmem_cnt;
    logic               r_upg_rst;
    logic               r_cpu_rst;
    logic               r_err;

    // Writes reach the memories only while the programmer is live.
    assign w_accept   = upg_wen_i & ((r_state == S_ARM) || (r_state == S_LOAD));
    assign imem_wen_o = w_accept & ~upg_adr_i[14];
    assign dmem_wen_o = w_accept &  upg_adr_i[14];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_arm_entry = 1'b0;
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start_pg) begin
                        w_next      = S_ARM;
                        w_arm_entry = 1'b1;
                    end
                end
                S_ARM: begin
                    if (upg_done_i)     w_next = S_DRAIN;
                    else if (upg_wen_i) w_next = S_LOAD;
                end
                S_LOAD: begin
                    if (upg_done_i)                             w_next = S_DRAIN;
                    else if (!upg_wen_i && (r_tmo == C_TMO_LAST)) w_next = S_ERROR;
                end
                S_DRAIN: begin
                    if (r_drain == C_DRN_LAST) w_next = S_RUN;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Status outputs are decoded from the next state so they change with state_o.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_upg_rst <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_upg_rst <= (w_next == S_IDLE) || (w_next == S_RUN) || (w_next == S_ERROR);
            r_cpu_rst <= (w_next != S_RUN);
            if (w_next == S_ERROR) begin
                r_err <= 1'b1;
            end else if (w_arm_entry) begin
                r_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo   <= '0;
            r_drain <= '0;
        end else begin
            if ((r_state == S_LOAD) && !upg_wen_i) r_tmo <= r_tmo + 1'b1;
            else                                   r_tmo <= '0;
            if (r_state == S_DRAIN) r_drain <= r_drain + 1'b1;
            else                    r_drain <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_imem_cnt <= '0;
            r_dmem_cnt <= '0;
        end else if (w_arm_entry) begin
            r_imem_cnt <= '0;
            r_dmem_cnt <= '0;
        end else if (w_accept) begin
            if (!upg_adr_i[14] && (r_imem_cnt != C_CNT_MAX)) r_imem_cnt <= r_imem_cnt + 1'b1;
            if ( upg_adr_i[14] && (r_dmem_cnt != C_CNT_MAX)) r_dmem_cnt <= r_dmem_cnt + 1'b1;
        end
    end

`ifdef UPG_CHECKSUM_EN
    logic [31:0] r_chk;
    logic        w_unused_adr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_chk <= '0;
        end else if (w_arm_entry) begin
            r_chk <= '0;
        end else if (w_accept) begin
            r_chk <= r_chk + upg_dat_i;
        end
    end

    assign chk_o        = r_chk;
    assign w_unused_adr = ^upg_adr_i[13:0];
`else
    logic w_unused_in;

    assign chk_o       = '0;
    assign w_unused_in = ^{upg_adr_i[13:0], upg_dat_i};
`endif

    assign upg_rst_o  = r_upg_rst;
    assign cpu_rst_o  = r_cpu_rst;
    assign err_o      = r_err;
    assign imem_cnt_o = r_imem_cnt;
    assign dmem_cnt_o = r_dmem_cnt;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_upg_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_upg_session_ctrl
// Purpose  : Directed vector bench for upg_session_ctrl (honours UPG_CHECKSUM_EN).
// Revision : 1.0
// ============================================================================
module tb_upg_session_ctrl;

    localparam int TIMEOUT_CYC = 100;
    localparam int DRAIN_CYC   = 16;
    localparam int CNT_W       = 15;
`ifdef UPG_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic             clock;
    logic             reset_n;
    logic             start_pg;
    logic             abort;
    logic             upg_wen_i;
    logic [14:0]      upg_adr_i;
    logic [31:0]      upg_dat_i;
    logic             upg_done_i;
    logic             upg_rst_o;
    logic             cpu_rst_o;
    logic             imem_wen_o;
    logic             dmem_wen_o;
    logic [CNT_W-1:0] imem_cnt_o;
    logic [CNT_W-1:0] dmem_cnt_o;
    logic [2:0]       state_o;
    logic             err_o;
    logic [31:0]      chk_o;

    int n_checks = 0;
    int n_fail   = 0;

    upg_session_ctrl #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .DRAIN_CYC  (DRAIN_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start_pg  (start_pg),
        .abort     (abort),
        .upg_wen_i (upg_wen_i),
        .upg_adr_i (upg_adr_i),
        .upg_dat_i (upg_dat_i),
        .upg_done_i(upg_done_i),
        .upg_rst_o (upg_rst_o),
        .cpu_rst_o (cpu_rst_o),
        .imem_wen_o(imem_wen_o),
        .dmem_wen_o(dmem_wen_o),
        .imem_cnt_o(imem_cnt_o),
        .dmem_cnt_o(dmem_cnt_o),
        .state_o   (state_o),
        .err_o     (err_o),
        .chk_o     (chk_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        start;
        logic        abrt;
        logic        wen;
        logic [14:0] adr;
        logic [31:0] dat;
        logic        done;
        logic        exp_iw;
        logic        exp_dw;
        logic [2:0]  exp_st;
        logic        exp_urst;
        logic        exp_crst;
        logic [14:0] exp_ic;
        logic [14:0] exp_dc;
        logic [31:0] exp_chk;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [31:0] ck(input logic [31:0] x);
        return CHK_ON ? x : 32'h0;
    endfunction

    function automatic vec_t mk(input logic s, input logic a, input logic w,
                                input logic [14:0] adr, input logic [31:0] d, input logic dn,
                                input logic iw, input logic dw, input logic [2:0] st,
                                input logic ur, input logic cr, input logic [14:0] ic,
                                input logic [14:0] dc, input logic [31:0] chk);
        vec_t v;
        v.start = s;    v.abrt = a;     v.wen = w;     v.adr = adr;   v.dat = d;
        v.done = dn;    v.exp_iw = iw;  v.exp_dw = dw; v.exp_st = st;
        v.exp_urst = ur; v.exp_crst = cr; v.exp_ic = ic; v.exp_dc = dc; v.exp_chk = chk;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic w,
                         input logic [14:0] adr, input logic [31:0] d, input logic dn);
        @(negedge clock);
        start_pg   = s;
        abort      = a;
        upg_wen_i  = w;
        upg_adr_i  = adr;
        upg_dat_i  = d;
        upg_done_i = dn;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic s, input logic a, input logic w,
                        input logic [14:0] adr, input logic [31:0] d, input logic dn);
        drive(s, a, w, adr, d, dn);
        tick();
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.start, v.abrt, v.wen, v.adr, v.dat, v.done);
        check($sformatf("v%0d_imem_wen", idx), 32'(imem_wen_o), 32'(v.exp_iw));
        check($sformatf("v%0d_dmem_wen", idx), 32'(dmem_wen_o), 32'(v.exp_dw));
        tick();
        check($sformatf("v%0d_state", idx),    32'(state_o),    32'(v.exp_st));
        check($sformatf("v%0d_upg_rst", idx),  32'(upg_rst_o),  32'(v.exp_urst));
        check($sformatf("v%0d_cpu_rst", idx),  32'(cpu_rst_o),  32'(v.exp_crst));
        check($sformatf("v%0d_imem_cnt", idx), 32'(imem_cnt_o), 32'(v.exp_ic));
        check($sformatf("v%0d_dmem_cnt", idx), 32'(dmem_cnt_o), 32'(v.exp_dc));
        check($sformatf("v%0d_chk", idx),      chk_o,           v.exp_chk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drain_seen;
        int idle_cyc;
        bit left;

        reset_n    = 1'b0;
        start_pg   = 1'b0;
        abort      = 1'b0;
        upg_wen_i  = 1'b0;
        upg_adr_i  = '0;
        upg_dat_i  = '0;
        upg_done_i = 1'b0;

        // Download session: 4 imem words, 2 dmem words, then done.
        tbl[0]  = mk(1, 0, 0, 15'h0000, 32'h0000_0000, 0,  0, 0, 3'd1, 0, 1, 15'd0, 15'd0, ck(32'h0));
        tbl[1]  = mk(0, 0, 1, 15'h0000, 32'hFFFF_FFFF, 0,  1, 0, 3'd2, 0, 1, 15'd1, 15'd0, ck(32'hFFFF_FFFF));
        tbl[2]  = mk(0, 0, 1, 15'h0001, 32'h0000_0002, 0,  1, 0, 3'd2, 0, 1, 15'd2, 15'd0, ck(32'h1));
        tbl[3]  = mk(0, 0, 0, 15'h0000, 32'h0000_0000, 0,  0, 0, 3'd2, 0, 1, 15'd2, 15'd0, ck(32'h1));
        tbl[4]  = mk(0, 0, 1, 15'h0002, 32'h0000_0010, 0,  1, 0, 3'd2, 0, 1, 15'd3, 15'd0, ck(32'h11));
        tbl[5]  = mk(0, 0, 1, 15'h0003, 32'h0000_0000, 0,  1, 0, 3'd2, 0, 1, 15'd4, 15'd0, ck(32'h11));
        tbl[6]  = mk(1, 0, 0, 15'h0000, 32'h0000_0000, 0,  0, 0, 3'd2, 0, 1, 15'd4, 15'd0, ck(32'h11));
        tbl[7]  = mk(0, 0, 1, 15'h4000, 32'h0000_0100, 0,  0, 1, 3'd2, 0, 1, 15'd4, 15'd1, ck(32'h111));
        tbl[8]  = mk(0, 0, 1, 15'h4001, 32'h0000_1000, 0,  0, 1, 3'd2, 0, 1, 15'd4, 15'd2, ck(32'h1111));
        tbl[9]  = mk(0, 0, 0, 15'h0000, 32'h0000_0000, 1,  0, 0, 3'd3, 0, 1, 15'd4, 15'd2, ck(32'h1111));
        tbl[10] = mk(0, 0, 1, 15'h0004, 32'h0000_ABCD, 0,  0, 0, 3'd3, 0, 1, 15'd4, 15'd2, ck(32'h1111));

        repeat (3) @(posedge clock);
        #1;
        check("rst_state",    32'(state_o),    32'd0);
        check("rst_upg_rst",  32'(upg_rst_o),  32'd1);
        check("rst_cpu_rst",  32'(cpu_rst_o),  32'd1);
        check("rst_imem_cnt", 32'(imem_cnt_o), 32'd0);
        check("rst_dmem_cnt", 32'(dmem_cnt_o), 32'd0);
        check("rst_err",      32'(err_o),      32'd0);
        check("rst_chk",      chk_o,           32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) apply_vec(tbl[i], i);

        // Two DRAIN cycles already observed by the table.
        drain_seen = 2;
        left = 1'b0;
        for (int n = 0; n < 40 && !left; n++) begin
            step(0, 0, 0, 15'h0, 32'h0, 0);
            if (state_o == 3'd3) drain_seen++;
            else left = 1'b1;
        end
        check("drain_length",  32'(drain_seen), 32'(DRAIN_CYC));
        check("run_state",     32'(state_o),    32'd4);
        check("run_cpu_rst",   32'(cpu_rst_o),  32'd0);
        check("run_upg_rst",   32'(upg_rst_o),  32'd1);

        // Timeout: one write then silence.
        step(1, 0, 0, 15'h0, 32'h0, 0);
        check("rearm_state",    32'(state_o),    32'd1);
        check("rearm_imem_cnt", 32'(imem_cnt_o), 32'd0);
        check("rearm_dmem_cnt", 32'(dmem_cnt_o), 32'd0);
        check("rearm_chk",      chk_o,           32'd0);
        step(0, 0, 1, 15'h0010, 32'h5, 0);
        check("tmo_load_state", 32'(state_o),    32'd2);
        idle_cyc = 0;
        left = 1'b0;
        for (int n = 0; n < 2 * TIMEOUT_CYC && !left; n++) begin
            step(0, 0, 0, 15'h0, 32'h0, 0);
            idle_cyc++;
            if (idle_cyc == TIMEOUT_CYC / 2) begin
                check("tmo_mid_state", 32'(state_o), 32'd2);
                check("tmo_mid_err",   32'(err_o),   32'd0);
            end
            if (state_o == 3'd5) left = 1'b1;
        end
        check("tmo_idle_cycles", 32'(idle_cyc),  32'(TIMEOUT_CYC));
        check("tmo_state",       32'(state_o),   32'd5);
        check("tmo_err",         32'(err_o),     32'd1);
        check("tmo_cpu_rst",     32'(cpu_rst_o), 32'd1);
        check("tmo_upg_rst",     32'(upg_rst_o), 32'd1);
        step(0, 0, 0, 15'h0, 32'h0, 0);
        check("err_hold_state",  32'(state_o),   32'd5);
        step(1, 0, 0, 15'h0, 32'h0, 0);
        check("err_rearm_state", 32'(state_o),   32'd1);
        check("err_rearm_err",   32'(err_o),     32'd0);
        check("err_rearm_upg",   32'(upg_rst_o), 32'd0);

        // Write and done in the same ARM cycle.
        drive(0, 0, 1, 15'h4005, 32'h7, 1);
        check("wd_dmem_wen", 32'(dmem_wen_o), 32'd1);
        check("wd_imem_wen", 32'(imem_wen_o), 32'd0);
        tick();
        check("wd_state",    32'(state_o),    32'd3);
        check("wd_dmem_cnt", 32'(dmem_cnt_o), 32'd1);
        check("wd_imem_cnt", 32'(imem_cnt_o), 32'd0);
        check("wd_chk",      chk_o,           ck(32'h7));
        left = 1'b0;
        for (int n = 0; n < 40 && !left; n++) begin
            step(0, 0, 0, 15'h0, 32'h0, 0);
            if (state_o != 3'd3) left = 1'b1;
        end
        check("wd_run_state", 32'(state_o), 32'd4);

        // Abort beats start in LOAD; writes in IDLE are blocked.
        step(1, 0, 0, 15'h0, 32'h0, 0);
        step(0, 0, 1, 15'h0007, 32'h3, 0);
        check("ab_load_state", 32'(state_o),    32'd2);
        step(1, 1, 0, 15'h0, 32'h0, 0);
        check("ab_state",      32'(state_o),    32'd0);
        check("ab_upg_rst",    32'(upg_rst_o),  32'd1);
        check("ab_cpu_rst",    32'(cpu_rst_o),  32'd1);
        check("ab_imem_hold",  32'(imem_cnt_o), 32'd1);
        drive(0, 0, 1, 15'h0000, 32'h9, 0);
        check("idle_imem_wen", 32'(imem_wen_o), 32'd0);
        tick();
        drive(0, 0, 1, 15'h4000, 32'h9, 0);
        check("idle_dmem_wen", 32'(dmem_wen_o), 32'd0);
        tick();
        check("idle_imem_cnt", 32'(imem_cnt_o), 32'd1);
        check("idle_dmem_cnt", 32'(dmem_cnt_o), 32'd0);
        check("idle_state",    32'(state_o),    32'd0);
        check("idle_chk",      chk_o,           ck(32'h3));

        // Asynchronous reset in the middle of a session.
        step(1, 0, 0, 15'h0, 32'h0, 0);
        step(0, 0, 1, 15'h0001, 32'h4, 0);
        check("mid_load_cnt", 32'(imem_cnt_o), 32'd1);
        @(negedge clock);
        upg_wen_i = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("mid_rst_state",   32'(state_o),    32'd0);
        check("mid_rst_upg_rst", 32'(upg_rst_o),  32'd1);
        check("mid_rst_cpu_rst", 32'(cpu_rst_o),  32'd1);
        check("mid_rst_imem",    32'(imem_cnt_o), 32'd0);
        check("mid_rst_chk",     chk_o,           32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
